hazard_track: RTL and testbench

//  Producer-side companion of the D-stage control unit: carries each instruction's

---
 rtl/hazard_track_pkg.sv | 32 +++
 rtl/hazard_track_fwd_sel.sv | 26 ++
 rtl/hazard_track.sv | 86 ++++++++
 tb/tb_hazard_track.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_track_pkg.sv
// Shared pipeline-tag types, forwarding select codes and Tnew ageing helper.
// Pure declarations: no latency, no flow control.
package pipe_pkg;

    localparam int ADDR_W = 5;
    localparam int TNEW_W = 2;
    localparam int NSTAGE = 3;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TNEW_W-1:0] tnew;
    } stage_tag_t;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - TNEW_W'(1);
    endfunction

    // Stage list index 0 is E (youngest), 1 is M, 2 is W.
    function automatic logic [1:0] stage_code(input int idx);
        case (idx)
            0:       return FWD_E;
            1:       return FWD_M;
            default: return FWD_W;
        endcase
    endfunction

endpackage

// File: rtl/hazard_track_fwd_sel.sv
// Forwarding select for one source operand: youngest enabled matching stage wins.
// Combinational, 0-cycle latency; no flow control.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [ADDR_W-1:0]             src_i,
    input  stage_tag_t [NSTAGE-1:0]       tags_i,
    input  logic [NSTAGE-1:0]             en_i,
    output logic [1:0]                    sel_o
);

    logic hit;

    // A younger match that is not ready yet shadows older stages and yields GRF.
    always_comb begin
        sel_o = FWD_GRF;
        hit   = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (!hit && en_i[i] && (src_i != '0) && (src_i == tags_i[i].addr)) begin
                hit   = 1'b1;
                sel_o = (tags_i[i].tnew == '0) ? stage_code(i) : FWD_GRF;
            end
        end
    end

endmodule

// File: rtl/hazard_track.sv
// E/M/W write-tag pipeline with Tnew ageing, forwarding selects and stall counter.
// Tags advance every edge (E takes a bubble on stall); selects are 0-cycle combinational.
module hazard_track
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [ADDR_W-1:0] reg_addr_D,
    input  logic [TNEW_W-1:0] Tnew_D,
    input  logic [ADDR_W-1:0] rs_D,
    input  logic [ADDR_W-1:0] rt_D,
    input  logic [ADDR_W-1:0] rs_E,
    input  logic [ADDR_W-1:0] rt_E,
    input  logic [ADDR_W-1:0] rt_M,
    output logic [ADDR_W-1:0] reg_addr_E,
    output logic [ADDR_W-1:0] reg_addr_M,
    output logic [ADDR_W-1:0] reg_addr_W,
    output logic [TNEW_W-1:0] Tnew_E,
    output logic [TNEW_W-1:0] Tnew_M,
    output logic [1:0]        fwd_rs_D,
    output logic [1:0]        fwd_rt_D,
    output logic [1:0]        fwd_rs_E,
    output logic [1:0]        fwd_rt_E,
    output logic              fwd_rt_M,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_tag_t              tag_e_q, tag_e_d;
    stage_tag_t              tag_m_q, tag_m_d;
    logic [ADDR_W-1:0]       addr_w_q, addr_w_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    stage_tag_t [NSTAGE-1:0] stages;
    logic [1:0]              sel_rt_m;

    always_comb begin
        tag_e_d = '0;
        if (!stall) begin
            tag_e_d.addr = reg_addr_D;
            tag_e_d.tnew = Tnew_D;
        end
        tag_m_d.addr = tag_e_q.addr;
        tag_m_d.tnew = sat_dec(tag_e_q.tnew);
        addr_w_d     = tag_m_q.addr;
        stall_cnt_d  = stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_e_q     <= '0;
            tag_m_q     <= '0;
            addr_w_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            tag_e_q     <= tag_e_d;
            tag_m_q     <= tag_m_d;
            addr_w_q    <= addr_w_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // W results are always ready, so its Tnew is tied to zero.
    always_comb begin
        stages[0]      = tag_e_q;
        stages[1]      = tag_m_q;
        stages[2].addr = addr_w_q;
        stages[2].tnew = '0;
    end

    fwd_sel u_fwd_rs_d (.src_i(rs_D), .tags_i(stages), .en_i(3'b111), .sel_o(fwd_rs_D));
    fwd_sel u_fwd_rt_d (.src_i(rt_D), .tags_i(stages), .en_i(3'b111), .sel_o(fwd_rt_D));
    fwd_sel u_fwd_rs_e (.src_i(rs_E), .tags_i(stages), .en_i(3'b110), .sel_o(fwd_rs_E));
    fwd_sel u_fwd_rt_e (.src_i(rt_E), .tags_i(stages), .en_i(3'b110), .sel_o(fwd_rt_E));
    fwd_sel u_fwd_rt_m (.src_i(rt_M), .tags_i(stages), .en_i(3'b100), .sel_o(sel_rt_m));

    assign fwd_rt_M   = (sel_rt_m == FWD_W);
    assign reg_addr_E = tag_e_q.addr;
    assign Tnew_E     = tag_e_q.tnew;
    assign reg_addr_M = tag_m_q.addr;
    assign Tnew_M     = tag_m_q.tnew;
    assign reg_addr_W = addr_w_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_track.sv
// Directed and random checks of hazard_track against a per-instruction history model.
module tb_hazard_track;
    import pipe_pkg::*;

    localparam int CNT_W = 3;

    logic              clk = 1'b0;
    logic              reset, stall;
    logic [ADDR_W-1:0] reg_addr_D, rs_D, rt_D, rs_E, rt_E, rt_M;
    logic [TNEW_W-1:0] Tnew_D;
    logic [ADDR_W-1:0] reg_addr_E, reg_addr_M, reg_addr_W;
    logic [TNEW_W-1:0] Tnew_E, Tnew_M;
    logic [1:0]        fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic              fwd_rt_M;
    logic [CNT_W-1:0]  stall_cnt;

    hazard_track #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .reg_addr_D(reg_addr_D), .Tnew_D(Tnew_D),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
        .reg_addr_E(reg_addr_E), .reg_addr_M(reg_addr_M), .reg_addr_W(reg_addr_W),
        .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E),
        .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: history of what entered E, newest first; each entry keeps its original Tnew.
    int q_addr[$];
    int q_t[$];
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_addr = {0, 0, 0};
        q_t    = {0, 0, 0};
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        q_addr.push_front(stall ? 0 : int'(reg_addr_D));
        q_t.push_front(stall ? 0 : int'(Tnew_D));
        void'(q_addr.pop_back());
        void'(q_t.pop_back());
        if (stall) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    endtask

    // Remaining Tnew of the entry that has been in the pipe for k edges beyond E.
    function automatic int m_tnew(input int k);
        return (q_t[k] - k > 0) ? q_t[k] - k : 0;
    endfunction

    function automatic int m_fwd(input int src, input int first);
        for (int k = first; k < 3; k++)
            if (src != 0 && q_addr[k] == src)
                return (m_tnew(k) == 0) ? k + 1 : 0;
        return 0;
    endfunction

    task automatic check_model();
        chk("reg_addr_E", 32'(reg_addr_E), q_addr[0]);
        chk("Tnew_E",     32'(Tnew_E),     m_tnew(0));
        chk("reg_addr_M", 32'(reg_addr_M), q_addr[1]);
        chk("Tnew_M",     32'(Tnew_M),     m_tnew(1));
        chk("reg_addr_W", 32'(reg_addr_W), q_addr[2]);
        chk("stall_cnt",  32'(stall_cnt),  m_cnt);
        chk("fwd_rs_D",   32'(fwd_rs_D),   m_fwd(int'(rs_D), 0));
        chk("fwd_rt_D",   32'(fwd_rt_D),   m_fwd(int'(rt_D), 0));
        chk("fwd_rs_E",   32'(fwd_rs_E),   m_fwd(int'(rs_E), 1));
        chk("fwd_rt_E",   32'(fwd_rt_E),   m_fwd(int'(rt_E), 1));
        chk("fwd_rt_M",   32'(fwd_rt_M),   (m_fwd(int'(rt_M), 2) == 3) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        #1;
    endtask

    task automatic set_d(input logic s, input int a, input int t);
        stall      = s;
        reg_addr_D = ADDR_W'(a);
        Tnew_D     = TNEW_W'(t);
    endtask

    task automatic set_src(input int a, input int b, input int c, input int d, input int e);
        rs_D = ADDR_W'(a); rt_D = ADDR_W'(b); rs_E = ADDR_W'(c); rt_E = ADDR_W'(d); rt_M = ADDR_W'(e);
    endtask

    initial begin
        reset = 1'b0;
        set_d(1'b0, 0, 0);
        set_src(0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("rst_addr_E", 32'(reg_addr_E), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_fwd_rs_D", 32'(fwd_rs_D), 0);
        check_model();
        @(negedge clk);
        reset = 1'b1;

        // Tnew ageing through E, M, W
        set_d(1'b0, 8, 2);
        tick();
        chk("age_E_addr", 32'(reg_addr_E), 8);
        chk("age_E_tnew", 32'(Tnew_E), 2);
        set_d(1'b0, 0, 0);
        tick();
        chk("age_M_addr", 32'(reg_addr_M), 8);
        chk("age_M_tnew", 32'(Tnew_M), 1);
        tick();
        chk("age_W_addr", 32'(reg_addr_W), 8);
        chk("age_M_no_underflow", 32'(Tnew_M), 0);
        check_model();

        // Bubble on stall
        set_d(1'b0, 5, 2);
        tick();
        set_d(1'b1, 9, 1);
        tick();
        chk("bubble_E_addr", 32'(reg_addr_E), 0);
        chk("bubble_E_tnew", 32'(Tnew_E), 0);
        chk("bubble_M_addr", 32'(reg_addr_M), 5);
        chk("bubble_M_tnew", 32'(Tnew_M), 1);
        chk("bubble_cnt", 32'(stall_cnt), 1);
        check_model();

        // Asynchronous reset between edges
        set_d(1'b0, 5, 1);
        tick();
        chk("pre_rst_E_addr", 32'(reg_addr_E), 5);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_E_addr", 32'(reg_addr_E), 0);
        chk("async_rst_E_tnew", 32'(Tnew_E), 0);
        chk("async_rst_cnt", 32'(stall_cnt), 0);
        model_reset();
        check_model();
        #1 reset = 1'b1;

        // D-stage priority and shadowing
        set_d(1'b0, 3, 0);
        tick(); tick(); tick();
        set_src(3, 3, 0, 0, 0);
        #1;
        chk("prio_rs_D_E", 32'(fwd_rs_D), 1);
        check_model();
        set_d(1'b0, 3, 1);
        tick();
        chk("shadow_rs_D", 32'(fwd_rs_D), 0);
        chk("shadow_rt_D", 32'(fwd_rt_D), 0);
        check_model();

        // E/M-stage forwarding
        set_d(1'b0, 4, 0);
        tick();
        set_d(1'b0, 0, 0);
        tick();
        set_src(0, 0, 0, 4, 0);
        #1;
        chk("fwd_rt_E_M", 32'(fwd_rt_E), 2);
        set_d(1'b0, 4, 0);
        tick();
        set_d(1'b0, 7, 0);
        tick();
        set_d(1'b0, 0, 0);
        tick();
        set_src(0, 0, 0, 4, 4);
        #1;
        chk("fwd_rt_E_W", 32'(fwd_rt_E), 3);
        chk("fwd_rt_M_W", 32'(fwd_rt_M), 1);
        check_model();

        // Zero register never forwarded
        tick(); tick(); tick();
        set_src(0, 0, 0, 0, 0);
        #1;
        chk("zero_rs_D", 32'(fwd_rs_D), 0);
        chk("zero_rt_E", 32'(fwd_rt_E), 0);
        chk("zero_rt_M", 32'(fwd_rt_M), 0);
        check_model();

        // Stall counter wrap after 2^CNT_W stalls
        set_d(1'b1, 6, 2);
        for (int i = 0; i < 7; i++) tick();
        chk("cnt_seven", 32'(stall_cnt), 7);
        tick();
        chk("cnt_wrap", 32'(stall_cnt), 0);
        check_model();

        // Random traffic with small address space to provoke matches
        for (int i = 0; i < 400; i++) begin
            set_d($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 2));
            set_src($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7));
            #1;
            check_model();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
